// File: rtl/avalon_bus_arbiter_if.sv
// Avalon-MM link bundle: one instance per master-to-arbiter or arbiter-to-slave hop.
// The master modport drives the request; the slave modport answers with waitrequest/readdata.
interface avalon_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;

  // A transfer completes in any cycle where (read|write) is high and waitrequest is low.
  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Two-master round-robin Avalon-MM arbiter with a bounded per-grant hold count.
// The owning master is muxed onto the slave combinationally; the other master is stalled.
module avalon_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_bus_arbiter_if.slave  m0,
  avalon_bus_arbiter_if.slave  m1,
  avalon_bus_arbiter_if.master s,
  output logic [1:0]           grant,
  output logic [1:0]           fsm_state
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state, state_next;
  logic          last, last_next;
  logic [HW-1:0] hold_cnt, hold_next;

  logic   req0, req1, own_req, oth_req, own_id, at_limit;
  logic [HW:0] hold_inc;
  state_t other_state;

  assign req0        = m0.read | m0.write;
  assign req1        = m1.read | m1.write;
  assign own_id      = (state == GRANT1);
  assign own_req     = own_id ? req1 : req0;
  assign oth_req     = own_id ? req0 : req1;
  assign other_state = own_id ? GRANT0 : GRANT1;
  assign hold_inc    = {1'b0, hold_cnt} + (HW + 1)'(1);
  assign at_limit    = (hold_inc >= {1'b0, HOLD_MAX});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      last     <= last_next;
      hold_cnt <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    last_next  = last;
    hold_next  = hold_cnt;
    unique case (state)
      IDLE: begin
        hold_next = '0;
        // On a tie the master that did not own the bus last goes first.
        if (req0 && (!req1 || last)) state_next = GRANT0;
        else if (req1)               state_next = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (!own_req) begin
          last_next  = own_id;
          hold_next  = '0;
          state_next = oth_req ? other_state : IDLE;
        end else if (!s.waitrequest) begin
          if (at_limit && oth_req) begin
            state_next = other_state;
            last_next  = own_id;
            hold_next  = '0;
          end else begin
            hold_next = at_limit ? HOLD_MAX : hold_inc[HW-1:0];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slave strobes depend only on the state register, so an async reset drops them at once.
  always_comb begin
    s.address      = '0;
    s.read         = 1'b0;
    s.write        = 1'b0;
    s.writedata    = '0;
    s.byteenable   = '0;
    m0.waitrequest = 1'b1;
    m1.waitrequest = 1'b1;
    grant          = 2'b00;
    unique case (state)
      GRANT0: begin
        s.address      = m0.address;
        s.read         = m0.read;
        s.write        = m0.write;
        s.writedata    = m0.writedata;
        s.byteenable   = m0.byteenable;
        m0.waitrequest = s.waitrequest;
        grant          = 2'b01;
      end
      GRANT1: begin
        s.address      = m1.address;
        s.read         = m1.read;
        s.write        = m1.write;
        s.writedata    = m1.writedata;
        s.byteenable   = m1.byteenable;
        m1.waitrequest = s.waitrequest;
        grant          = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0.readdata = s.readdata;
  assign m1.readdata = s.readdata;
  assign fsm_state   = state;
endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Scenario bench for avalon_bus_arbiter with MAX_HOLD=4: reset, single read, tie,
// hold limit, saturation, long stall and asynchronous reset in the middle of a stall.
module tb_avalon_bus_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_HOLD = 4;
  localparam int EW       = 4 + AW;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] grant;
  logic [1:0] fsm_state;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [EW-1:0] exp_q[$];

  avalon_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
  avalon_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
  avalon_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();

  avalon_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .grant     (grant),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_bus.address = '0; m0_bus.read = 1'b0; m0_bus.write = 1'b0;
    m0_bus.writedata = '0; m0_bus.byteenable = '0;
    m1_bus.address = '0; m1_bus.read = 1'b0; m1_bus.write = 1'b0;
    m1_bus.writedata = '0; m1_bus.byteenable = '0;
    s_bus.waitrequest = 1'b0; s_bus.readdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) tick();
    reset = 1'b1;
  endtask

  // Expected {grant, m1_waitrequest, m0_waitrequest, s_address} with an unstalled slave.
  function automatic logic [EW-1:0] exp_entry(input logic [1:0] g, input logic [AW-1:0] a0,
                                               input logic [AW-1:0] a1);
    case (g)
      2'b01:   return {g, 1'b1, 1'b0, a0};
      2'b10:   return {g, 1'b0, 1'b1, a1};
      default: return {g, 2'b11, {AW{1'b0}}};
    endcase
  endfunction

  function automatic logic [EW-1:0] observe();
    return {grant, m1_bus.waitrequest, m0_bus.waitrequest, s_bus.address};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m0_bus.read = 1'($urandom_range(0, 1)); m0_bus.write = 1'($urandom_range(0, 1));
      m1_bus.read = 1'($urandom_range(0, 1)); m1_bus.write = 1'($urandom_range(0, 1));
      m0_bus.address = $urandom(); m1_bus.address = $urandom();
      m0_bus.writedata = $urandom(); m1_bus.writedata = $urandom();
      s_bus.waitrequest = 1'($urandom_range(0, 1));
      #3;
      n_cmp++;
      if ({s_bus.read, s_bus.write, grant, m0_bus.waitrequest, m1_bus.waitrequest} !== 6'b000011) begin
        n_err++;
        $display("FAIL reset_ctrl: got %b expected 000011",
                 {s_bus.read, s_bus.write, grant, m0_bus.waitrequest, m1_bus.waitrequest});
      end
      n_cmp++;
      if (s_bus.address !== '0 || s_bus.writedata !== '0) begin
        n_err++;
        $display("FAIL reset_bus: addr %h data %h expected 0", s_bus.address, s_bus.writedata);
      end
      tick();
    end
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    m0_bus.read = 1'b1; m0_bus.address = 32'hBFC0_0000;
    s_bus.waitrequest = 1'b0; s_bus.readdata = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if ({grant, m0_bus.waitrequest, s_bus.read} !== 4'b0010) begin
      n_err++;
      $display("FAIL read_arb_cycle: got %b expected 0010", {grant, m0_bus.waitrequest, s_bus.read});
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({grant, m0_bus.waitrequest, s_bus.read} !== 4'b0101) begin
      n_err++;
      $display("FAIL read_grant: got %b expected 0101", {grant, m0_bus.waitrequest, s_bus.read});
    end
    n_cmp++;
    if (s_bus.address !== 32'hBFC0_0000) begin
      n_err++;
      $display("FAIL read_addr: got %h expected bfc00000", s_bus.address);
    end
    n_cmp++;
    if (m0_bus.readdata !== 32'h1234_5678 || m1_bus.readdata !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL read_data: m0 %h m1 %h expected 12345678", m0_bus.readdata, m1_bus.readdata);
    end
    tick();
    m0_bus.read = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (grant !== 2'b00) begin
      n_err++;
      $display("FAIL read_release: got %b expected 00", grant);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_tie();
    do_reset();
    m0_bus.read = 1'b1; m0_bus.address = 32'h200;
    m1_bus.write = 1'b1; m1_bus.address = 32'h100;
    m1_bus.writedata = 32'hDEAD_BEEF; m1_bus.byteenable = 4'hF;
    @(negedge clk);
    n_cmp++;
    if ({grant, m1_bus.waitrequest, m0_bus.waitrequest} !== 4'b0011) begin
      n_err++;
      $display("FAIL tie_arb: got %b expected 0011", {grant, m1_bus.waitrequest, m0_bus.waitrequest});
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({grant, s_bus.read, s_bus.write, m1_bus.waitrequest} !== 5'b01101) begin
      n_err++;
      $display("FAIL tie_m0_first: got %b expected 01101",
               {grant, s_bus.read, s_bus.write, m1_bus.waitrequest});
    end
    tick();
    m0_bus.read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (grant !== 2'b01) begin
      n_err++;
      $display("FAIL tie_drop_cycle: got %b expected 01", grant);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({grant, s_bus.write, m1_bus.waitrequest} !== 4'b1010) begin
      n_err++;
      $display("FAIL tie_switch: got %b expected 1010", {grant, s_bus.write, m1_bus.waitrequest});
    end
    n_cmp++;
    if (s_bus.writedata !== 32'hDEAD_BEEF || s_bus.address !== 32'h100 || s_bus.byteenable !== 4'hF) begin
      n_err++;
      $display("FAIL tie_wdata: data %h addr %h be %h expected deadbeef 100 f",
               s_bus.writedata, s_bus.address, s_bus.byteenable);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_hold_limit();
    logic [EW-1:0] obs, exp;
    do_reset();
    m0_bus.read = 1'b1; m0_bus.address = 32'hA000;
    m1_bus.read = 1'b1; m1_bus.address = 32'hB000;
    exp_q.push_back(exp_entry(2'b00, 32'hA000, 32'hB000));
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_entry(2'b01, 32'hA000, 32'hB000));
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_entry(2'b10, 32'hA000, 32'hB000));
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_entry(2'b01, 32'hA000, 32'hB000));
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      obs = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL hold_limit cyc %0d: got %h expected %h", c, obs, exp);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_saturate();
    logic [EW-1:0] obs, exp;
    do_reset();
    m0_bus.read = 1'b1; m0_bus.address = 32'hA000;
    m1_bus.address = 32'hB000;
    exp_q.push_back(exp_entry(2'b00, 32'hA000, 32'hB000));
    for (int i = 0; i < 6; i++) exp_q.push_back(exp_entry(2'b01, 32'hA000, 32'hB000));
    exp_q.push_back(exp_entry(2'b10, 32'hA000, 32'hB000));
    for (int c = 0; c < 8; c++) begin
      m1_bus.read = (c >= 6);
      @(negedge clk);
      obs = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL saturate cyc %0d: got %h expected %h", c, obs, exp);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    m1_bus.write = 1'b1; m1_bus.address = 32'h300; m1_bus.writedata = 32'hCAFE_F00D;
    s_bus.waitrequest = 1'b1;
    tick();
    m0_bus.read = 1'b1; m0_bus.address = 32'h400;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({grant, s_bus.write, m0_bus.waitrequest, m1_bus.waitrequest} !== 5'b10111) begin
        n_err++;
        $display("FAIL stall cyc %0d: got %b expected 10111", c,
                 {grant, s_bus.write, m0_bus.waitrequest, m1_bus.waitrequest});
      end
      tick();
    end
    s_bus.waitrequest = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({grant, m0_bus.waitrequest, m1_bus.waitrequest} !== 4'b1010) begin
      n_err++;
      $display("FAIL stall_complete: got %b expected 1010",
               {grant, m0_bus.waitrequest, m1_bus.waitrequest});
    end
    tick();
    m1_bus.write = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({grant, s_bus.read, s_bus.address} !== {2'b01, 1'b1, 32'h400}) begin
      n_err++;
      $display("FAIL stall_handover: got %b %b %h expected 01 1 400", grant, s_bus.read, s_bus.address);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    m1_bus.write = 1'b1; m1_bus.address = 32'h300;
    s_bus.waitrequest = 1'b1;
    tick();
    m0_bus.read = 1'b1; m0_bus.address = 32'h400;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({grant, s_bus.write} !== 3'b101) begin
      n_err++;
      $display("FAIL midstall_pre: got %b expected 101", {grant, s_bus.write});
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({grant, s_bus.write, s_bus.read, m0_bus.waitrequest, m1_bus.waitrequest} !== 6'b000011) begin
      n_err++;
      $display("FAIL midstall_async: got %b expected 000011",
               {grant, s_bus.write, s_bus.read, m0_bus.waitrequest, m1_bus.waitrequest});
    end
    tick();
    reset = 1'b1;
    s_bus.waitrequest = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (grant !== 2'b00) begin
      n_err++;
      $display("FAIL midstall_idle: got %b expected 00", grant);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({grant, s_bus.read, s_bus.write} !== 4'b0110) begin
      n_err++;
      $display("FAIL midstall_regrant: got %b expected 0110", {grant, s_bus.read, s_bus.write});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_hold_limit();
    test_saturate();
    test_stall();
    test_reset_mid_stall();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
